// File: rtl/uigr_io_drivers.sv
// uIGR I/O back end: button debouncer, LED feedback sequencer and CIC reset pulse generator.
// All logic runs on clk; asynchronous trigger inputs are synchronised internally.
module uigr_io_drivers #(
    parameter int unsigned DEBOUNCE_TICKS    = 500_000,
    parameter bit          DEBOUNCE_INVERT   = 1'b1,
    parameter int unsigned LED_STEP_TICKS    = 12_500_000,
    parameter int unsigned SHORT_RESET_TICKS = 12_500_000,
    parameter int unsigned LONG_RESET_TICKS  = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       reset_button,
    output logic       btn_debounced,
    input  logic [3:0] led_pattern,
    input  logic       led_start,
    output logic [1:0] led,
    output logic       led_busy,
    input  logic       rst_pattern,
    input  logic       rst_start,
    output logic       cic_reset,
    output logic       rst_busy
);

    localparam int unsigned DB_W    = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam int unsigned LED_W   = (LED_STEP_TICKS > 1) ? $clog2(LED_STEP_TICKS) : 1;
    localparam int unsigned RST_MAX = (LONG_RESET_TICKS > SHORT_RESET_TICKS) ?
                                      LONG_RESET_TICKS : SHORT_RESET_TICKS;
    localparam int unsigned RST_W   = (RST_MAX > 1) ? $clog2(RST_MAX) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_PULSE = 1'b1
    } rst_state_t;

    // Debouncer state
    logic [1:0]      r_btn_sync;
    logic            r_stable;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_btn_out;

    // Trigger synchronisers
    logic [1:0]      r_led_sync;
    logic            r_led_dly;
    logic            r_led_pulse;
    logic [1:0]      r_rst_sync;
    logic            r_rst_dly;
    logic            r_rst_pulse;

    // LED sequencer state
    logic [3:0]      r_led_code;
    logic [1:0]      r_led_step;
    logic [LED_W-1:0] r_led_tick;
    logic [1:0]      r_led;
    logic            r_led_busy;

    // Reset pulse FSM
    rst_state_t      r_rst_state;
    rst_state_t      w_rst_state_nxt;
    logic [RST_W-1:0] r_rst_cnt;
    logic [RST_W-1:0] w_rst_cnt_nxt;
    logic            r_cic;
    logic            w_cic_nxt;

    // Pattern table: LED value for a given code and step (unknown codes give 00)
    function automatic logic [1:0] led_value(input logic [3:0] code, input logic [1:0] step);
        logic [1:0] v;
        v = 2'b00;
        case (code)
            4'b0001: v = 2'b01;
            4'b0010: v = 2'b10;
            4'b0011: v = 2'b11;
            4'b0100: v = step[0] ? 2'b00 : 2'b01;
            4'b0101: v = step[0] ? 2'b00 : 2'b10;
            4'b0110: v = step[0] ? 2'b00 : 2'b11;
            4'b0111: v = (step == 2'd0) ? 2'b11 : 2'b00;
            4'b1000: v = step[0] ? 2'b01 : 2'b10;
            4'b1010: v = step[0] ? 2'b10 : 2'b01;
            default: v = 2'b00;
        endcase
        return v;
    endfunction

    function automatic logic code_valid(input logic [3:0] code);
        logic ok;
        ok = 1'b0;
        case (code)
            4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
            4'b0110, 4'b0111, 4'b1000, 4'b1010: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Debounce: stable level follows the synced button after DEBOUNCE_TICKS differing clocks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_sync <= 2'b00;
            r_stable   <= 1'b1;
            r_db_cnt   <= '0;
            r_btn_out  <= DEBOUNCE_INVERT ? 1'b0 : 1'b1;
        end else begin
            r_btn_sync <= {r_btn_sync[0], reset_button};
            if (r_btn_sync[1] == r_stable) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_W'(DEBOUNCE_TICKS - 1)) begin
                r_db_cnt  <= '0;
                r_stable  <= r_btn_sync[1];
                r_btn_out <= DEBOUNCE_INVERT ? ~r_btn_sync[1] : r_btn_sync[1];
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    // Trigger edge detection: 2-flop sync, delay flop, registered single-cycle pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led_sync  <= 2'b00;
            r_led_dly   <= 1'b0;
            r_led_pulse <= 1'b0;
            r_rst_sync  <= 2'b00;
            r_rst_dly   <= 1'b0;
            r_rst_pulse <= 1'b0;
        end else begin
            r_led_sync  <= {r_led_sync[0], led_start};
            r_led_dly   <= r_led_sync[1];
            r_led_pulse <= r_led_sync[1] & ~r_led_dly;
            r_rst_sync  <= {r_rst_sync[0], rst_start};
            r_rst_dly   <= r_rst_sync[1];
            r_rst_pulse <= r_rst_sync[1] & ~r_rst_dly;
        end
    end

    // LED sequencer: four steps of LED_STEP_TICKS each; a valid start always restarts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led_code <= 4'b0000;
            r_led_step <= 2'd0;
            r_led_tick <= '0;
            r_led      <= 2'b00;
            r_led_busy <= 1'b0;
        end else if (r_led_pulse && code_valid(led_pattern)) begin
            r_led_code <= led_pattern;
            r_led_step <= 2'd0;
            r_led_tick <= '0;
            r_led      <= led_value(led_pattern, 2'd0);
            r_led_busy <= 1'b1;
        end else if (r_led_busy) begin
            if (r_led_tick == LED_W'(LED_STEP_TICKS - 1)) begin
                r_led_tick <= '0;
                if (r_led_step == 2'd3) begin
                    r_led      <= 2'b00;
                    r_led_busy <= 1'b0;
                end else begin
                    r_led_step <= r_led_step + 2'd1;
                    r_led      <= led_value(r_led_code, r_led_step + 2'd1);
                end
            end else begin
                r_led_tick <= r_led_tick + LED_W'(1);
            end
        end
    end

    // Reset FSM state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rst_state <= ST_IDLE;
            r_rst_cnt   <= '0;
            r_cic       <= 1'b0;
        end else begin
            r_rst_state <= w_rst_state_nxt;
            r_rst_cnt   <= w_rst_cnt_nxt;
            r_cic       <= w_cic_nxt;
        end
    end

    // Reset FSM next state: load remaining-cycle count on start, count down to zero
    always_comb begin
        w_rst_state_nxt = r_rst_state;
        w_rst_cnt_nxt   = r_rst_cnt;
        w_cic_nxt       = r_cic;
        case (r_rst_state)
            ST_IDLE: begin
                w_cic_nxt = 1'b0;
                if (r_rst_pulse) begin
                    w_rst_state_nxt = ST_PULSE;
                    w_rst_cnt_nxt   = rst_pattern ? RST_W'(LONG_RESET_TICKS - 1)
                                                  : RST_W'(SHORT_RESET_TICKS - 1);
                    w_cic_nxt       = 1'b1;
                end
            end
            ST_PULSE: begin
                if (r_rst_cnt == '0) begin
                    w_rst_state_nxt = ST_IDLE;
                    w_cic_nxt       = 1'b0;
                end else begin
                    w_rst_cnt_nxt = r_rst_cnt - RST_W'(1);
                    w_cic_nxt     = 1'b1;
                end
            end
            default: begin
                w_rst_state_nxt = ST_IDLE;
                w_rst_cnt_nxt   = '0;
                w_cic_nxt       = 1'b0;
            end
        endcase
    end

    assign btn_debounced = r_btn_out;
    assign led           = r_led;
    assign led_busy      = r_led_busy;
    assign cic_reset     = r_cic;
    assign rst_busy      = r_cic;

endmodule

// File: tb/tb_uigr_io_drivers.sv
// Bench for uigr_io_drivers: directed and randomized stimulus against a timeline-based reference model.
module tb_uigr_io_drivers;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       reset_button = 1'b1;
    logic       btn_debounced;
    logic [3:0] led_pattern = 4'b0000;
    logic       led_start = 1'b0;
    logic [1:0] led;
    logic       led_busy;
    logic       rst_pattern = 1'b0;
    logic       rst_start = 1'b0;
    logic       cic_reset;
    logic       rst_busy;

    uigr_io_drivers #(
        .DEBOUNCE_TICKS   (4),
        .DEBOUNCE_INVERT  (1'b1),
        .LED_STEP_TICKS   (3),
        .SHORT_RESET_TICKS(5),
        .LONG_RESET_TICKS (10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .reset_button (reset_button),
        .btn_debounced(btn_debounced),
        .led_pattern  (led_pattern),
        .led_start    (led_start),
        .led          (led),
        .led_busy     (led_busy),
        .rst_pattern  (rst_pattern),
        .rst_start    (rst_start),
        .cic_reset    (cic_reset),
        .rst_busy     (rst_busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: button history, LED/reset windows on the cycle timeline
    bit         hist [0:4095];
    bit         m_stable;
    logic [7:0] seq [16];
    bit         lvalid [16];
    int         lt0, rt0, rlen;
    logic [3:0] lcode;
    bit         pl_valid, pr_valid;
    int         pl_t, pr_t;
    logic [3:0] pl_code;
    logic       pr_pat;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_stable = 1'b1;
        lt0 = -1000; rt0 = -1000; rlen = 0; lcode = 4'b0000;
        pl_valid = 1'b0; pr_valid = 1'b0;
        for (int i = 0; i < 4096; i++) hist[i] = 1'b1;
    endtask

    task automatic model_edge();
        bit all_diff;
        if (rst) return;
        if (pl_valid && cyc == pl_t) begin
            pl_valid = 1'b0;
            if (lvalid[pl_code]) begin lt0 = cyc; lcode = pl_code; end
        end
        if (pr_valid && cyc == pr_t) begin
            pr_valid = 1'b0;
            if (!(cyc > rt0 && cyc <= rt0 + rlen)) begin
                rt0 = cyc; rlen = pr_pat ? 10 : 5;
            end
        end
        if (cyc >= 6) begin
            all_diff = 1'b1;
            for (int k = 3; k <= 6; k++) if (hist[cyc-k] == m_stable) all_diff = 1'b0;
            if (all_diff) m_stable = ~m_stable;
        end
    endtask

    task automatic check_all();
        logic [1:0] e_led;
        logic [7:0] s;
        logic       e_lbusy, e_cic;
        int         idx;
        e_lbusy = (cyc >= lt0) && (cyc < lt0 + 12);
        e_led = 2'b00;
        if (e_lbusy) begin
            idx = (cyc - lt0) / 3;
            s = seq[lcode] >> (6 - 2 * idx);
            e_led = s[1:0];
        end
        e_cic = (cyc >= rt0) && (cyc < rt0 + rlen);
        chk1("btn_debounced", btn_debounced, ~m_stable);
        chk2("led", led, e_led);
        chk1("led_busy", led_busy, e_lbusy);
        chk1("cic_reset", cic_reset, e_cic);
        chk1("rst_busy", rst_busy, e_cic);
    endtask

    task automatic step();
        hist[cyc] = reset_button;
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic trig_led(input logic [3:0] code, input int hold);
        led_pattern = code;
        led_start = 1'b1;
        pl_valid = 1'b1; pl_t = cyc + 4; pl_code = code;
        steps(hold);
        led_start = 1'b0;
        steps(2);
    endtask

    task automatic trig_rst(input logic pat, input int hold);
        rst_pattern = pat;
        rst_start = 1'b1;
        pr_valid = 1'b1; pr_t = cyc + 4; pr_pat = pat;
        steps(hold);
        rst_start = 1'b0;
        steps(2);
    endtask

    task automatic button(input logic lvl, input int n);
        reset_button = lvl;
        steps(n);
    endtask

    initial begin
        logic [3:0] vcodes [9];
        for (int i = 0; i < 16; i++) begin seq[i] = 8'h00; lvalid[i] = 1'b0; end
        seq[4'b0001] = 8'b01_01_01_01; seq[4'b0010] = 8'b10_10_10_10;
        seq[4'b0011] = 8'b11_11_11_11; seq[4'b0100] = 8'b01_00_01_00;
        seq[4'b0101] = 8'b10_00_10_00; seq[4'b0110] = 8'b11_00_11_00;
        seq[4'b0111] = 8'b11_00_00_00; seq[4'b1000] = 8'b10_01_10_01;
        seq[4'b1010] = 8'b01_10_01_10;
        vcodes = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                   4'b0110, 4'b0111, 4'b1000, 4'b1010};
        foreach (vcodes[i]) lvalid[vcodes[i]] = 1'b1;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        steps(3);

        // Short button glitch never reaches the output
        button(1'b0, 2);
        button(1'b1, 10);
        for (int g = 0; g < 3; g++) begin
            button(1'b0, int'($urandom_range(1, 3)));
            button(1'b1, int'($urandom_range(4, 8)));
        end

        // Long press, then release
        button(1'b0, 8);
        button(1'b1, 12);
        for (int g = 0; g < 3; g++) begin
            button(1'b0, int'($urandom_range(4, 9)));
            button(1'b1, int'($urandom_range(6, 10)));
        end

        // LED timeout-on sequence
        trig_led(4'b0100, 2);
        steps(14);

        // Retrigger at step 2 with a new code
        trig_led(4'b0001, 2);
        steps(2);
        trig_led(4'b1010, 2);
        steps(14);

        // Invalid code: idle stays idle, busy keeps playing
        trig_led(4'b1111, 2);
        steps(4);
        trig_led(4'b0011, 2);
        trig_led(4'b1111, 2);
        steps(12);

        // Random valid codes, occasionally retriggering
        for (int r = 0; r < 5; r++) begin
            trig_led(vcodes[$urandom_range(0, 8)], 2);
            steps(int'($urandom_range(0, 12)));
        end
        steps(14);

        // CIC reset pulses
        trig_rst(1'b0, 2);
        steps(8);
        trig_rst(1'b1, 2);
        trig_rst(1'b0, 2);
        steps(12);
        for (int r = 0; r < 4; r++) begin
            trig_rst(1'($urandom_range(0, 1)), 2);
            steps(int'($urandom_range(0, 12)));
        end
        steps(14);

        // Held trigger gives exactly one sequence
        trig_led(4'b0010, 50);
        steps(6);

        // Asynchronous reset during activity
        trig_led(4'b0110, 2);
        trig_rst(1'b1, 2);
        steps(1);
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        steps(2);
        rst = 1'b0;
        steps(16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
